// File: rtl/sll.sv
// 32-bit shift-left-logical unit: 5-stage logarithmic barrel shifter
// feeding a single output register with asynchronous active-high reset.
module sll (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);

    logic [31:0] stage [6];

    assign stage[0] = a;

    // Stage k shifts by 2^k when shamt[k] is set, zero-filling the low bits.
    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage[k+1] = shamt[k] ? {stage[k][31-SH:0], {SH{1'b0}}} : stage[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
        end else begin
            y <= stage[5];
        end
    end

endmodule

// File: tb/tb_sll.sv
// Self-checking bench for sll: a cycle-level reference model checked on every
// falling edge, plus directed vectors with hand-computed results.
module tb_sll;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] y;

    int errors = 0;
    int checks = 0;

    sll dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .shamt (shamt),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the registered value is simply a << shamt, cleared by reset.
    logic [31:0] model_y;
    bit          model_valid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_y     <= 32'h0;
            model_valid <= 1'b1;
        end else begin
            model_y <= a << shamt;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (y !== model_y) begin
                errors++;
                $display("FAIL model_cmp t=%0t a=%h shamt=%0d y=%h expected=%h",
                         $time, a, shamt, y, model_y);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] expected);
        checks++;
        if (y !== expected) begin
            errors++;
            $display("FAIL %s t=%0t y=%h expected=%h", name, $time, y, expected);
        end
    endtask

    // Drive inputs just after a rising edge so they are stable for the next one.
    task automatic drive(input logic [31:0] va, input logic [4:0] vs);
        @(posedge clk);
        #1;
        a     = va;
        shamt = vs;
    endtask

    task automatic vec(input string name, input logic [31:0] va,
                       input logic [4:0] vs, input logic [31:0] expected);
        drive(va, vs);
        @(posedge clk);
        #1;
        check(name, expected);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        a     = 32'h0;
        shamt = 5'd0;
        #2;
        check("reset_state", 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 32'h0);
        reset = 1'b0;

        vec("shamt0", 32'h0000_002D, 5'd0, 32'h0000_002D);

        // Back-to-back inputs: each result lands exactly one edge later.
        drive(32'h0000_002D, 5'd1);
        @(posedge clk);
        #1;
        check("seq_s1", 32'h0000_005A);
        shamt = 5'd2;
        @(posedge clk);
        #1;
        check("seq_s2", 32'h0000_00B4);

        vec("one_s31",   32'h0000_0001, 5'd31, 32'h8000_0000);
        vec("ones_s16",  32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000);
        vec("msb_drop",  32'h8000_0001, 5'd1,  32'h0000_0002);
        vec("zero_s13",  32'h0000_0000, 5'd13, 32'h0000_0000);
        vec("beef_s4",   32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0);
        vec("beef_s31",  32'hDEAD_BEEF, 5'd31, 32'h8000_0000);
        vec("a5_s7",     32'hA5A5_A5A5, 5'd7,  32'hD2D2_D280);

        for (int s = 0; s < 32; s++) begin
            drive(32'hDEAD_BEEF, 5'(s));
        end
        @(posedge clk);
        #1;
        check("sweep_last", 32'h8000_0000);

        // Reset asserted between edges while y holds 0xB4.
        vec("pre_reset", 32'h0000_002D, 5'd2, 32'h0000_00B4);
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", 32'h0);
        a     = 32'h0000_0003;
        shamt = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        check("reset_2edges", 32'h0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_load", 32'h0000_0030);

        // Inputs changed twice between edges: y holds until the next edge.
        a     = 32'h0000_00FF;
        shamt = 5'd8;
        #2;
        a     = 32'h0000_0001;
        shamt = 5'd3;
        #1;
        check("toggle_hold", 32'h0000_0030);
        @(posedge clk);
        #1;
        check("toggle_load", 32'h0000_0008);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
